// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg -- shared types and helpers for the ppc_lsu load/store unit.
//
// Contents:
//   size_t     request size encoding (byte / half / word / reserved)
//   state_t    LSU control state encoding
//   byteen_of  big-endian byte-enable pattern for a store of a given size at
//              a given (already normalised) byte offset. Bit 3 of the result
//              selects byte offset 0, i.e. data bits 31:24.
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic [3:0] byteen_of(input size_t size, input logic [1:0] off);
    logic [3:0] be;
    unique case (size)
      SZ_BYTE: be = 4'b1000 >> off;
      SZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage : lsu_pkg

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align -- combinational lane logic for ppc_lsu (big-endian byte order).
//
// Store side: replicates right-justified store data across all lanes and
// produces the byte enables for the addressed lanes.
// Load side : selects the addressed byte/half from the sram read word and
// zero- or sign-extends it to 32 bits.
//
// Offsets supplied here are already normalised by the caller (half uses
// off[1] only, word uses 0), so no alignment checking happens in this block.
//
// Ports:
//   st_size, st_off, st_wdata   store request size, byte offset, data
//   st_byteen, st_data          sram byte enables and lane-replicated data
//   ld_size, ld_off, ld_sext    load size, byte offset, sign-extend flag
//   ld_q                        raw sram read word
//   ld_data                     right-justified, extended load result
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  size_t       st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_byteen,
  output logic [31:0] st_data,
  input  size_t       ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_sext,
  input  logic [31:0] ld_q,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign st_byteen = byteen_of(st_size, st_off);

  always_comb begin
    unique case (st_size)
      SZ_BYTE: st_data = {4{st_wdata[7:0]}};
      SZ_HALF: st_data = {2{st_wdata[15:0]}};
      SZ_WORD: st_data = st_wdata;
      default: st_data = 32'h0;
    endcase
  end

  // Byte offset 0 is the most significant lane.
  always_comb begin
    unique case (ld_off)
      2'd0:    ld_byte = ld_q[31:24];
      2'd1:    ld_byte = ld_q[23:16];
      2'd2:    ld_byte = ld_q[15:8];
      default: ld_byte = ld_q[7:0];
    endcase
  end

  assign ld_half = ld_off[1] ? ld_q[15:0] : ld_q[31:16];

  always_comb begin
    unique case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_sext & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_sext & ld_half[15]}}, ld_half};
      SZ_WORD: ld_data = ld_q;
      default: ld_data = 32'h0;
    endcase
  end

endmodule : lsu_align

// File: rtl/ppc_lsu.sv
// -----------------------------------------------------------------------------
// ppc_lsu -- single-outstanding load/store unit in front of an AW-bit word
// addressed, 32-bit sram with one cycle of read latency.
//
// Flow: IDLE accepts a request; errors go straight to RESP; good requests
// strobe the sram for one cycle in ISSUE; loads then spend one cycle in WAIT
// to capture sram_q; RESP holds the response until resp_ready.
// Every output is a register.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake
//   req_we, req_size, req_sext       store flag, size, load sign-extend
//   req_addr, req_wdata              byte address, right-justified store data
//   resp_valid/resp_ready            response handshake
//   resp_rdata, resp_err             load result (0 for stores/errors), error
//   sram_addr, sram_byteen           word address, byte enables (bit3 = MSB)
//   sram_data, sram_rden, sram_wren  lane-replicated data, strobes
//   sram_q                           read data, valid the cycle after rden
//
// Build option:
//   LSU_ALIGN_CHECK_EN  when defined, misaligned half/word requests are
//                       errors; otherwise the low address bits are ignored.
// -----------------------------------------------------------------------------
module ppc_lsu
  import lsu_pkg::*;
#(
  parameter int AW = 13,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_sext,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] sram_addr,
  output logic [3:0]    sram_byteen,
  output logic [31:0]   sram_data,
  output logic          sram_rden,
  output logic          sram_wren,
  input  logic [31:0]   sram_q
);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  size_t      size_in;
  logic [1:0] off;
  logic [1:0] eff_off;
  logic       range_err;
  logic       align_err;
  logic       req_err;

  assign size_in = size_t'(req_size);
  assign off     = req_addr[1:0];

  // Half lanes are chosen by off[1] alone and words always start at lane 0,
  // whichever build is selected.
  always_comb begin
    unique case (size_in)
      SZ_BYTE: eff_off = off;
      SZ_HALF: eff_off = {off[1], 1'b0};
      default: eff_off = 2'd0;
    endcase
  end

  assign range_err = (req_addr >> (AW + 2)) != 32'h0;

`ifdef LSU_ALIGN_CHECK_EN
  assign align_err = ((size_in == SZ_HALF) && off[0]) ||
                     ((size_in == SZ_WORD) && (off != 2'd0));
`else
  assign align_err = 1'b0;
`endif

  assign req_err = range_err || align_err || (size_in == SZ_RSVD);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t        state, state_n;
  logic          we_q, we_n;
  size_t         ld_size_q, ld_size_n;
  logic [1:0]    ld_off_q, ld_off_n;
  logic          ld_sext_q, ld_sext_n;

  logic          req_ready_n;
  logic          resp_valid_n;
  logic [31:0]   resp_rdata_n;
  logic          resp_err_n;
  logic [AW-1:0] sram_addr_n;
  logic [3:0]    sram_byteen_n;
  logic [31:0]   sram_data_n;
  logic          sram_rden_n;
  logic          sram_wren_n;

  logic [3:0]    st_byteen;
  logic [31:0]   st_data;
  logic [31:0]   ld_data;

  lsu_align u_align (
    .st_size   (size_in),
    .st_off    (eff_off),
    .st_wdata  (req_wdata),
    .st_byteen (st_byteen),
    .st_data   (st_data),
    .ld_size   (ld_size_q),
    .ld_off    (ld_off_q),
    .ld_sext   (ld_sext_q),
    .ld_q      (sram_q),
    .ld_data   (ld_data)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_n       = state;
    we_n          = we_q;
    ld_size_n     = ld_size_q;
    ld_off_n      = ld_off_q;
    ld_sext_n     = ld_sext_q;
    req_ready_n   = req_ready;
    resp_valid_n  = resp_valid;
    resp_rdata_n  = resp_rdata;
    resp_err_n    = resp_err;
    sram_addr_n   = sram_addr;
    sram_byteen_n = sram_byteen;
    sram_data_n   = sram_data;
    sram_rden_n   = 1'b0;          // strobes are single-cycle pulses
    sram_wren_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          req_ready_n = 1'b0;
          if (req_err) begin
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
            resp_rdata_n = 32'h0;
            state_n      = RESP;
          end else begin
            we_n        = req_we;
            sram_addr_n = req_addr[AW+1:2];
            state_n     = ISSUE;
            if (req_we) begin
              sram_wren_n   = 1'b1;
              sram_byteen_n = st_byteen;
              sram_data_n   = st_data;
            end else begin
              // Loads read the whole word; lane selection happens on return.
              sram_rden_n   = 1'b1;
              sram_byteen_n = 4'b1111;
              ld_size_n     = size_in;
              ld_off_n      = eff_off;
              ld_sext_n     = req_sext;
            end
          end
        end
      end

      ISSUE: begin
        if (we_q) begin
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b0;
          resp_rdata_n = 32'h0;
          state_n      = RESP;
        end else begin
          state_n = WAIT;
        end
      end

      WAIT: begin
        resp_valid_n = 1'b1;
        resp_err_n   = 1'b0;
        resp_rdata_n = ld_data;
        state_n      = RESP;
      end

      RESP: begin
        if (resp_ready) begin
          resp_valid_n = 1'b0;
          req_ready_n  = 1'b1;
          state_n      = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      ld_size_q   <= SZ_BYTE;
      ld_off_q    <= 2'd0;
      ld_sext_q   <= 1'b0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'h0;
      resp_err    <= 1'b0;
      sram_addr   <= '0;
      sram_byteen <= 4'b0000;
      sram_data   <= 32'h0;
      sram_rden   <= 1'b0;
      sram_wren   <= 1'b0;
    end else begin
      state       <= state_n;
      we_q        <= we_n;
      ld_size_q   <= ld_size_n;
      ld_off_q    <= ld_off_n;
      ld_sext_q   <= ld_sext_n;
      req_ready   <= req_ready_n;
      resp_valid  <= resp_valid_n;
      resp_rdata  <= resp_rdata_n;
      resp_err    <= resp_err_n;
      sram_addr   <= sram_addr_n;
      sram_byteen <= sram_byteen_n;
      sram_data   <= sram_data_n;
      sram_rden   <= sram_rden_n;
      sram_wren   <= sram_wren_n;
    end
  end

endmodule : ppc_lsu

// File: doc/ppc_lsu.md
Name: ppc_lsu

Overview:
- Load/store unit directly upstream of the 8K x 32 `sram` data memory.
- Accepts one CPU memory request at a time: byte, halfword or word; load or store; big-endian PowerPC byte order.
- Drives the sram's word address, byte enables, write data and rden/wren.
- Steers and sign-extends load data from the sram q output, and returns a single-beat response to the core with valid/ready backpressure.

Parameters:
- AW, 13, sram word-address width; the byte-address space is 2^(AW+2) bytes.
- DW, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as error).
- req_sext  in  1  sign-extend load result (lha); ignored for stores and for word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  load result, right-justified; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range, or reserved-size request.
- sram_addr  out  AW  word address, equal to req_addr[AW+1:2].
- sram_byteen  out  4  byte enables; bit 3 is byte offset 0 (bits 31:24).
- sram_data  out  32  write data, lane-replicated.
- sram_rden  out  1  sram read enable.
- sram_wren  out  1  sram write enable.
- sram_q  in  32  sram read data, valid the cycle after the rden edge.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; sram_rden=0; sram_wren=0; sram_addr=0; sram_byteen=0; sram_data=0.
- All outputs are registered.
- States:
  - IDLE: req_ready=1. An accepted request (req_valid & req_ready) is checked:
    - error -> RESP with resp_err=1 and no sram strobe.
    - store -> ISSUE with wren=1.
    - load -> ISSUE with rden=1.
  - ISSUE: sram strobes high for exactly one cycle.
    - store -> RESP.
    - load -> WAIT, with strobes dropped.
  - WAIT: at this edge sram_q is captured, steered, extended into resp_rdata -> RESP.
  - RESP: resp_valid=1; hold resp_rdata and resp_err until resp_ready=1, then -> IDLE.
- Latency from accept edge E0:
  - Error response visible after E0.
  - Store response after E1.
  - Load response after E2.
  - Back-to-back throughput: one request per 3 cycles (store) or 4 cycles (load), with resp_ready held high.
- No new request is accepted while resp_valid=1; req_ready=0 in every state except IDLE.
- Lane rules, with off = req_addr[1:0]:
  - Byte: byteen = 4'b1000 >> off; sram_data = {4{wdata[7:0]}}; load takes q[31-8*off -: 8].
  - Half: byteen = off[1] ? 4'b0011 : 4'b1100; sram_data = {2{wdata[15:0]}}; load takes the q half at off[1].
  - Word: byteen = 4'b1111; data passes straight through.
  - Loads always assert all four byteen bits, so the full word is read; the unused lanes are discarded.
- Extension: byte and half loads zero-extend unless req_sext=1, in which case they sign-extend.
- Range: req_addr[31:AW+2] != 0 -> error.
- Reset mid-operation:
  - Any pending strobe or response is dropped and the state returns to IDLE.
  - A store whose wren had already been sampled by the sram is not undone.

Optional Feature:
- Macro LSU_ALIGN_CHECK_EN.
- Defined:
  - Half with off[0]=1 is an error.
  - Word with off!=0 is an error.
  - Erroring requests produce no sram access.
- Undefined:
  - Misaligned requests are not errors; the low address bits are ignored. Half uses off[1] only; word uses off=0.
  - resp_err is still raised for out-of-range and reserved-size requests.

Decomposition:
- Package lsu_pkg:
  - Size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - State encoding IDLE, ISSUE, WAIT, RESP.
  - Function byteen_of(size, off).
- Sub-module lsu_align: combinational store replication, byteen generation, and load lane select plus extension. It is instantiated once in ppc_lsu; the FSM and registers stay in ppc_lsu.

Test Plan:
- Store word 0x12345678 @0x0, then load word @0x0 -> sram_byteen=1111 on the store; resp_rdata=0x12345678 two cycles after the load accept.
- Load byte @0x1, sext=0 -> 0x00000034. Load byte @0x3 -> 0x00000078.
- Store word 0x9876DEAD @0x4; load half @0x4 with sext=1 -> 0xFFFF9876; load half @0x6 with sext=0 -> 0x0000DEAD.
- Store half 0x5432 @0x2 -> byteen=0011, sram_data=0x54325432; then load word @0x0 -> 0x12345432.
- Load word @0x2 -> with LSU_ALIGN_CHECK_EN: resp_err=1, no rden pulse, response one cycle after accept. Without it: returns word @0x0.
- Hold resp_ready=0 for 5 cycles on a load -> resp_valid and resp_rdata stable and req_ready=0. Separately, pulse rst_n low in WAIT -> resp_valid stays 0 and req_ready=1 immediately.
